// File: rtl/backtrack_unit.sv
// rtl/backtrack_unit.sv - conflict backtrack sequencer over the trace table and assignment memory
module backtrack_unit #(
    parameter int VAR_W    = 9,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             unsat,
    output logic             timeout,
    output logic             tt_pop,
    output logic             tt_push,
    output logic             tt_type,
    output logic             tt_val,
    output logic [VAR_W-1:0] tt_var,
    input  logic             tt_done,
    input  logic             tt_empty,
    input  logic             tt_type_out,
    input  logic             tt_val_out,
    input  logic [VAR_W-1:0] tt_var_out,
    output logic             va_we,
    output logic [VAR_W-1:0] va_var,
    output logic [1:0]       va_state,
    output logic             flip_valid,
    output logic [VAR_W-1:0] flip_var,
    output logic             flip_val,
    output logic [9:0]       pop_count
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, POP_REQ, POP_WAIT, UNASSIGN, PUSH_FLIP, FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic               cap_type_q, cap_type_d;
    logic               cap_val_q, cap_val_d;
    logic [VAR_W-1:0]   cap_var_q, cap_var_d;
    logic [9:0]         pop_cnt_q, pop_cnt_d;
    logic               unsat_q, unsat_d;
    logic               timeout_q, timeout_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            cap_type_q <= 1'b0;
            cap_val_q  <= 1'b0;
            cap_var_q  <= '0;
            pop_cnt_q  <= '0;
            unsat_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            cap_type_q <= cap_type_d;
            cap_val_q  <= cap_val_d;
            cap_var_q  <= cap_var_d;
            pop_cnt_q  <= pop_cnt_d;
            unsat_q    <= unsat_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        cap_type_d = cap_type_q;
        cap_val_d  = cap_val_q;
        cap_var_d  = cap_var_q;
        pop_cnt_d  = pop_cnt_q;
        unsat_d    = unsat_q;
        timeout_d  = timeout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = POP_REQ;
                    pop_cnt_d = '0;
                    unsat_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            POP_REQ: begin
                state_d = POP_WAIT;
                wait_d  = '0;
            end
            POP_WAIT: begin
                if (tt_done) begin
                    if (tt_empty) begin
                        state_d = FINISH;
                        unsat_d = 1'b1;
                    end else begin
                        state_d    = UNASSIGN;
                        cap_type_d = tt_type_out;
                        cap_val_d  = tt_val_out;
                        cap_var_d  = tt_var_out;
                        if (pop_cnt_q != 10'd1023)
                            pop_cnt_d = pop_cnt_q + 10'd1;
                    end
                end else if (wait_q == CNT_W'(WAIT_MAX - 1)) begin
                    state_d   = FINISH;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            // Forced entries keep unwinding; the first decision found is the one to flip.
            UNASSIGN:  state_d = cap_type_q ? POP_REQ : PUSH_FLIP;
            PUSH_FLIP: state_d = FINISH;
            FINISH:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        unsat      = 1'b0;
        timeout    = 1'b0;
        pop_count  = '0;
        tt_pop     = 1'b0;
        tt_push    = 1'b0;
        tt_type    = 1'b0;
        tt_val     = 1'b0;
        tt_var     = '0;
        va_we      = 1'b0;
        va_var     = '0;
        va_state   = 2'b00;
        flip_valid = 1'b0;
        flip_var   = '0;
        flip_val   = 1'b0;
        // Outputs are masked while reset is low so an abort never leaks a strobe.
        if (reset) begin
            unsat     = unsat_q;
            timeout   = timeout_q;
            pop_count = pop_cnt_q;
            busy      = (state_q != IDLE) && (state_q != FINISH);
            case (state_q)
                POP_REQ:  tt_pop = 1'b1;
                UNASSIGN: begin
                    va_we  = 1'b1;
                    va_var = cap_var_q;
                end
                PUSH_FLIP: begin
                    tt_push    = 1'b1;
                    tt_type    = 1'b1;
                    tt_val     = ~cap_val_q;
                    tt_var     = cap_var_q;
                    va_we      = 1'b1;
                    va_var     = cap_var_q;
                    va_state   = cap_val_q ? 2'b01 : 2'b10;
                    flip_valid = 1'b1;
                    flip_var   = cap_var_q;
                    flip_val   = ~cap_val_q;
                end
                FINISH:   done = 1'b1;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_backtrack_unit.sv
// tb/tb_backtrack_unit.sv - scoreboard bench for backtrack_unit with a trace-table responder
module tb_backtrack_unit;

    logic       clk, reset, start;
    logic       busy, done, unsat, timeout, tt_pop, tt_push, tt_type, tt_val;
    logic [8:0] tt_var, va_var, flip_var, tt_var_out;
    logic       tt_done, tt_empty, tt_type_out, tt_val_out;
    logic       va_we, flip_valid, flip_val;
    logic [1:0] va_state;
    logic [9:0] pop_count;

    logic       resp_done, man_done, resp_en;
    assign tt_done = resp_done | man_done;

    backtrack_unit #(.VAR_W(9), .WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .unsat(unsat), .timeout(timeout), .tt_pop(tt_pop), .tt_push(tt_push),
        .tt_type(tt_type), .tt_val(tt_val), .tt_var(tt_var), .tt_done(tt_done),
        .tt_empty(tt_empty), .tt_type_out(tt_type_out), .tt_val_out(tt_val_out),
        .tt_var_out(tt_var_out), .va_we(va_we), .va_var(va_var), .va_state(va_state),
        .flip_valid(flip_valid), .flip_var(flip_var), .flip_val(flip_val),
        .pop_count(pop_count)
    );

    typedef struct packed {
        logic       busy;
        logic       pop;
        logic       push;
        logic       ttype;
        logic       tval;
        logic [8:0] tvar;
        logic       we;
        logic [8:0] vvar;
        logic [1:0] vstate;
        logic       fv;
        logic [8:0] fvar;
        logic       fval;
        logic       done;
        logic       unsat;
        logic       tmo;
        logic [9:0] pcnt;
    } ev_t;

    typedef struct packed {
        logic       t;
        logic       v;
        logic [8:0] vr;
    } ent_t;

    ev_t  exp_q[$];
    ent_t trail[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, start_cyc = 0, lat_exp = 0, done_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t ev_pop(input logic [9:0] pc);
        ev_t e = '0;
        e.busy = 1'b1; e.pop = 1'b1; e.pcnt = pc;
        return e;
    endfunction

    function automatic ev_t ev_un(input logic [8:0] v, input logic [9:0] pc);
        ev_t e = '0;
        e.busy = 1'b1; e.we = 1'b1; e.vvar = v; e.vstate = 2'b00; e.pcnt = pc;
        return e;
    endfunction

    function automatic ev_t ev_flip(input logic [8:0] v, input logic nv,
                                    input logic [1:0] st, input logic [9:0] pc);
        ev_t e = '0;
        e.busy = 1'b1; e.push = 1'b1; e.ttype = 1'b1; e.tval = nv; e.tvar = v;
        e.we = 1'b1; e.vvar = v; e.vstate = st;
        e.fv = 1'b1; e.fvar = v; e.fval = nv; e.pcnt = pc;
        return e;
    endfunction

    function automatic ev_t ev_done(input logic u, input logic t, input logic [9:0] pc);
        ev_t e = '0;
        e.done = 1'b1; e.unsat = u; e.tmo = t; e.pcnt = pc;
        return e;
    endfunction

    // Trace-table model: answers a pop on the following cycle when enabled.
    initial begin
        resp_done = 1'b0; tt_empty = 1'b0; tt_type_out = 1'b0;
        tt_val_out = 1'b0; tt_var_out = '0;
        forever begin
            @(negedge clk);
            if (tt_pop && resp_en) begin
                @(posedge clk);
                #1;
                if (trail.size() == 0) begin
                    tt_empty = 1'b1;
                end else begin
                    ent_t e;
                    e = trail.pop_front();
                    tt_type_out = e.t; tt_val_out = e.v; tt_var_out = e.vr;
                end
                resp_done = 1'b1;
                @(posedge clk);
                #1;
                resp_done = 1'b0;
                tt_empty  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        ev_t obs;
        obs = {busy, tt_pop, tt_push, tt_type, tt_val, tt_var, va_we, va_var, va_state,
               flip_valid, flip_var, flip_val, done, unsat, timeout, pop_count};
        if (!reset) begin
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got %h, want 0", obs);
            end
        end else if (tt_pop | tt_push | va_we | flip_valid | done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event at cycle %0d: got %h, want none", cyc, obs);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("FAIL event at cycle %0d: got %h, want %h", cyc, obs, e);
                end
            end
            if (done) begin
                done_cnt++;
                checks++;
                if (cyc - start_cyc != lat_exp) begin
                    errors++;
                    $display("FAIL latency: got %0d, want %0d", cyc - start_cyc, lat_exp);
                end
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL leftover_events: got %0d pending, want 0", exp_q.size());
                end
            end
        end
    end

    task automatic pulse_start(input logic record);
        @(posedge clk);
        #1;
        start = 1'b1;
        if (record) start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int n = 0;
        while (done_cnt == prev && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == prev) begin
            $display("FAIL done_wait: got no done, want done within 200 cycles");
            $fatal(1, "bench stopped");
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic run_single_decision();
        int prev;
        trail.push_back('{t: 1'b0, v: 1'b1, vr: 9'd5});
        exp_q.push_back(ev_pop(10'd0));
        exp_q.push_back(ev_un(9'd5, 10'd1));
        exp_q.push_back(ev_flip(9'd5, 1'b0, 2'b01, 10'd1));
        exp_q.push_back(ev_done(1'b0, 1'b0, 10'd1));
        lat_exp = 5;
        prev = done_cnt;
        pulse_start(1'b1);
        wait_done(prev);
    endtask

    initial begin
        int prev;
        reset = 1'b0; start = 1'b0; man_done = 1'b0; resp_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);

        run_single_decision();

        trail.push_back('{t: 1'b1, v: 1'b1, vr: 9'd7});
        trail.push_back('{t: 1'b1, v: 1'b0, vr: 9'd3});
        trail.push_back('{t: 1'b0, v: 1'b0, vr: 9'd2});
        exp_q.push_back(ev_pop(10'd0));
        exp_q.push_back(ev_un(9'd7, 10'd1));
        exp_q.push_back(ev_pop(10'd1));
        exp_q.push_back(ev_un(9'd3, 10'd2));
        exp_q.push_back(ev_pop(10'd2));
        exp_q.push_back(ev_un(9'd2, 10'd3));
        exp_q.push_back(ev_flip(9'd2, 1'b1, 2'b10, 10'd3));
        exp_q.push_back(ev_done(1'b0, 1'b0, 10'd3));
        lat_exp = 11;
        prev = done_cnt;
        pulse_start(1'b1);
        wait_done(prev);

        exp_q.push_back(ev_pop(10'd0));
        exp_q.push_back(ev_done(1'b1, 1'b0, 10'd0));
        lat_exp = 3;
        prev = done_cnt;
        pulse_start(1'b1);
        wait_done(prev);

        resp_en = 1'b0;
        exp_q.push_back(ev_pop(10'd0));
        exp_q.push_back(ev_done(1'b0, 1'b1, 10'd0));
        lat_exp = 17;
        prev = done_cnt;
        pulse_start(1'b1);
        wait_done(prev);

        // Second start while busy must not restart or add a done.
        trail.push_back('{t: 1'b0, v: 1'b1, vr: 9'd5});
        resp_en = 1'b1;
        exp_q.push_back(ev_pop(10'd0));
        exp_q.push_back(ev_un(9'd5, 10'd1));
        exp_q.push_back(ev_flip(9'd5, 1'b0, 2'b01, 10'd1));
        exp_q.push_back(ev_done(1'b0, 1'b0, 10'd1));
        lat_exp = 5;
        prev = done_cnt;
        pulse_start(1'b1);
        pulse_start(1'b0);
        wait_done(prev);
        repeat (10) @(posedge clk);

        // Abort in POP_WAIT: the late response must have no effect.
        resp_en = 1'b0;
        exp_q.push_back(ev_pop(10'd0));
        pulse_start(1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        man_done = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        man_done = 1'b0;
        trail.delete();
        resp_en = 1'b1;
        repeat (3) @(posedge clk);
        run_single_decision();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
